// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace capture block: capture-state encoding and trace entry width.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int TRIG_SEL_W = 3;

    // Entry layout, MSB first: {timestamp, stall, stage words}.
    function automatic int entry_width(input int stages, input int iw, input int tsw);
        return stages * iw + 1 + tsw;
    endfunction

endpackage

// File: rtl/pipeline_trace_capture_if.sv
// Trace capture port bundle: pipeline taps and trigger/readout controls in, trace status and read data out.
// No handshake: inputs are sampled every cycle, outputs are plain registered status.
interface pipeline_trace_capture_if #(
    parameter int STAGES = 5,
    parameter int IW     = 32,
    parameter int DEPTH  = 64,
    parameter int TSW    = 16
) ();
    import trace_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(STAGES, IW, TSW);

    logic [STAGES*IW-1:0]  stage_instr;
    logic                  stall;
    logic                  arm;
    logic                  filter_stalls;
    logic [TRIG_SEL_W-1:0] trig_stage;
    logic [IW-1:0]         trig_value;
    logic [IW-1:0]         trig_mask;
    logic [AW-1:0]         post_count;
    logic [AW-1:0]         rd_idx;
    logic [EW-1:0]         rd_data;
    logic [1:0]            state;
    logic [AW:0]           count;
    logic [AW-1:0]         trig_pos;
    logic                  wrapped;

    modport master (
        output stage_instr, stall, arm, filter_stalls, trig_stage, trig_value,
               trig_mask, post_count, rd_idx,
        input  rd_data, state, count, trig_pos, wrapped
    );

    modport slave (
        input  stage_instr, stall, arm, filter_stalls, trig_stage, trig_value,
               trig_mask, post_count, rd_idx,
        output rd_data, state, count, trig_pos, wrapped
    );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace store: one write port, one registered read port (read-first on collision).
// Latency: 1 cycle read; backpressure: none, both ports accept every cycle.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 177,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pipeline_trace_capture.sv
// Circular trace of per-stage instruction words: arm, masked trigger at one stage, N post-trigger entries, freeze.
// Latency: entry written at the edge ending its cycle, 1-cycle readout; backpressure: none, never stalls the pipe.
module pipeline_trace_capture
    import trace_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int IW     = 32,
    parameter int DEPTH  = 64,
    parameter int TSW    = 16
) (
    input  logic clock,
    input  logic reset,
    pipeline_trace_capture_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          EW   = entry_width(STAGES, IW, TSW);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_e   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, post_lat_q, post_rem_q, trig_addr_q, trig_pos_q;
    logic [AW:0]    count_q;
    logic           wrapped_q, rd_zero_q;
    logic [TSW-1:0] ts_q;
    logic [EW-1:0]  ram_q;

    logic           eligible, hit, sel_ok;
    logic [IW-1:0]  sel_word;
    logic           wr_en, do_clear, trig_now, finish;
    logic [AW-1:0]  wr_ptr_inc, base_after, trig_phys, rd_base, rd_addr;
    logic           wrapped_d;

    // Out-of-range stage selects leave sel_ok low so they can never match.
    always_comb begin
        sel_word = '0;
        sel_ok   = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            if (bus.trig_stage == TRIG_SEL_W'(s)) begin
                sel_word = bus.stage_instr[s*IW +: IW];
                sel_ok   = 1'b1;
            end
        end
    end

    assign eligible = !(bus.filter_stalls && bus.stall);
    assign hit      = sel_ok && ((sel_word & bus.trig_mask) == (bus.trig_value & bus.trig_mask));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        do_clear = 1'b0;
        trig_now = 1'b0;
        finish   = 1'b0;
        if (bus.arm) begin
            state_d  = ST_ARMED;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (eligible) begin
                        wr_en = 1'b1;
                        if (hit) begin
                            trig_now = 1'b1;
                            if (post_lat_q == '0) begin
                                state_d = ST_DONE;
                                finish  = 1'b1;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (eligible) begin
                        wr_en = 1'b1;
                        if (post_rem_q == AW'(1)) begin
                            state_d = ST_DONE;
                            finish  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Trigger position uses the pointer/wrap state as it stands after the final write.
    assign wr_ptr_inc = wr_ptr_q + AW'(1);
    assign wrapped_d  = wrapped_q || (count_q == FULL);
    assign base_after = wrapped_d ? wr_ptr_inc : '0;
    assign trig_phys  = trig_now ? wr_ptr_q : trig_addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            ts_q        <= '0;
            post_lat_q  <= '0;
            post_rem_q  <= '0;
            trig_addr_q <= '0;
            trig_pos_q  <= '0;
            rd_zero_q   <= 1'b1;
        end else begin
            ts_q      <= do_clear ? '0 : ts_q + TSW'(1);
            rd_zero_q <= ({1'b0, bus.rd_idx} >= count_q);
            if (do_clear) begin
                wr_ptr_q   <= '0;
                count_q    <= '0;
                wrapped_q  <= 1'b0;
                trig_pos_q <= '0;
                post_lat_q <= bus.post_count;
            end
            if (wr_en) begin
                wr_ptr_q  <= wr_ptr_inc;
                wrapped_q <= wrapped_d;
                if (count_q != FULL) begin
                    count_q <= count_q + (AW+1)'(1);
                end
            end
            if (trig_now) begin
                trig_addr_q <= wr_ptr_q;
                post_rem_q  <= post_lat_q;
            end else if (wr_en && state_q == ST_POST) begin
                post_rem_q <= post_rem_q - AW'(1);
            end
            if (finish) begin
                trig_pos_q <= trig_phys - base_after;
            end
        end
    end

    assign rd_base = wrapped_q ? wr_ptr_q : '0;
    assign rd_addr = rd_base + bus.rd_idx;

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clock   (clock),
        .we      (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({ts_q, bus.stall, bus.stage_instr}),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign bus.rd_data  = rd_zero_q ? '0 : ram_q;
    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.trig_pos = trig_pos_q;
    assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// Bench for pipeline_trace_capture: two instances (DEPTH 64 and 8) share one stimulus stream,
// checked against an entry-history model plus hand-derived directed expectations.
module tb_pipeline_trace_capture;

    localparam int STAGES = 5;
    localparam int IW     = 32;
    localparam int TSW    = 16;
    localparam int EW     = STAGES * IW + 1 + TSW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [IW-1:0]        sw [STAGES];
    logic [STAGES*IW-1:0] stage_bus;
    logic                 stall, arm, filter_stalls;
    logic [2:0]           trig_stage;
    logic [IW-1:0]        trig_value, trig_mask;
    int                   post_count, rd_idx;

    always_comb begin
        stage_bus = '0;
        for (int s = 0; s < STAGES; s++) stage_bus[s*IW +: IW] = sw[s];
    end

    pipeline_trace_capture_if #(.STAGES(STAGES), .IW(IW), .DEPTH(64), .TSW(TSW)) if64 ();
    pipeline_trace_capture_if #(.STAGES(STAGES), .IW(IW), .DEPTH(8),  .TSW(TSW)) if8 ();

    assign if64.stage_instr = stage_bus;      assign if8.stage_instr = stage_bus;
    assign if64.stall = stall;                assign if8.stall = stall;
    assign if64.arm = arm;                    assign if8.arm = arm;
    assign if64.filter_stalls = filter_stalls; assign if8.filter_stalls = filter_stalls;
    assign if64.trig_stage = trig_stage;      assign if8.trig_stage = trig_stage;
    assign if64.trig_value = trig_value;      assign if8.trig_value = trig_value;
    assign if64.trig_mask = trig_mask;        assign if8.trig_mask = trig_mask;
    assign if64.post_count = 6'(post_count);  assign if8.post_count = 3'(post_count);
    assign if64.rd_idx = 6'(rd_idx);          assign if8.rd_idx = 3'(rd_idx);

    pipeline_trace_capture #(.STAGES(STAGES), .IW(IW), .DEPTH(64), .TSW(TSW)) u_dut64 (
        .clock (clock), .reset (reset), .bus (if64));
    pipeline_trace_capture #(.STAGES(STAGES), .IW(IW), .DEPTH(8), .TSW(TSW)) u_dut8 (
        .clock (clock), .reset (reset), .bus (if8));

    int checks = 0;
    int errors = 0;

    // Reference: every eligible entry since arm goes into hist; each depth has written
    // the first m_n[k] of them, stopping once trigger + post entries are in.
    logic [EW-1:0] hist [$];
    bit            m_on = 0;
    int            m_n [2], m_trig [2], m_pc [2];
    logic [TSW-1:0] m_ts = '0;

    function automatic int dep(int k);
        return (k == 0) ? 64 : 8;
    endfunction
    function automatic bit m_done(int k);
        return (m_trig[k] >= 0) && (m_n[k] >= m_trig[k] + 1 + m_pc[k]);
    endfunction
    function automatic int exp_state(int k);
        if (!m_on) return 0;
        if (m_trig[k] < 0) return 1;
        return m_done(k) ? 3 : 2;
    endfunction
    function automatic int exp_count(int k);
        return (m_n[k] < dep(k)) ? m_n[k] : dep(k);
    endfunction
    function automatic logic [EW-1:0] exp_rd(int k, int r);
        int c = exp_count(k);
        if (r >= c) return '0;
        return hist[m_n[k] - c + r];
    endfunction

    function automatic int dut_state(int k);
        return (k == 0) ? int'(if64.state) : int'(if8.state);
    endfunction
    function automatic int dut_count(int k);
        return (k == 0) ? int'(if64.count) : int'(if8.count);
    endfunction
    function automatic int dut_wrapped(int k);
        return (k == 0) ? int'(if64.wrapped) : int'(if8.wrapped);
    endfunction
    function automatic int dut_trig_pos(int k);
        return (k == 0) ? int'(if64.trig_pos) : int'(if8.trig_pos);
    endfunction
    function automatic logic [EW-1:0] dut_rd(int k);
        return (k == 0) ? if64.rd_data : if8.rd_data;
    endfunction

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic model_step();
        bit hit = 1'b0;
        bit elig = !(filter_stalls && stall);
        if (trig_stage < STAGES) hit = ((sw[trig_stage] & trig_mask) == (trig_value & trig_mask));
        if (reset) begin
            m_on = 0;
            hist.delete();
            for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_trig[k] = -1; end
        end else if (arm) begin
            m_on = 1;
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                m_n[k] = 0; m_trig[k] = -1; m_pc[k] = post_count % dep(k);
            end
        end else if (m_on && elig) begin
            hist.push_back({m_ts, stall, stage_bus});
            for (int k = 0; k < 2; k++) begin
                if (!m_done(k)) begin
                    m_n[k]++;
                    if (m_trig[k] < 0 && hit) m_trig[k] = m_n[k] - 1;
                end
            end
        end
        m_ts = (reset || arm) ? '0 : m_ts + 1'b1;
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d state", dep(k)), EW'(dut_state(k)), EW'(exp_state(k)));
            chk($sformatf("d%0d count", dep(k)), EW'(dut_count(k)), EW'(exp_count(k)));
            chk($sformatf("d%0d wrapped", dep(k)), EW'(dut_wrapped(k)), EW'(m_n[k] > dep(k)));
            if (m_on && m_done(k) && m_pc[k] < dep(k) - 1)
                chk($sformatf("d%0d trig_pos", dep(k)), EW'(dut_trig_pos(k)),
                    EW'(m_trig[k] - (m_n[k] - exp_count(k))));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        model_check();
    endtask

    task automatic start(input int pc, input int tsel, input logic [IW-1:0] tval,
                         input logic [IW-1:0] tmsk, input bit fs);
        post_count = pc; trig_stage = 3'(tsel); trig_value = tval; trig_mask = tmsk;
        filter_stalls = fs; stall = 0; rd_idx = 0;
        for (int s = 0; s < STAGES; s++) sw[s] = '0;
        arm = 1; tick(); arm = 0;
    endtask

    task automatic freeze();
        filter_stalls = 1; stall = 1; arm = 0;
    endtask

    typedef struct { bit st; logic [IW-1:0] w; int ecnt; } vec_t;
    vec_t tv [10];
    int rb_w [6];
    int rb_ts [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < STAGES; s++) sw[s] = '0;
        stall = 0; arm = 0; filter_stalls = 0; trig_stage = 0;
        trig_value = 0; trig_mask = 0; post_count = 0; rd_idx = 0;
        for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_trig[k] = -1; m_pc[k] = 0; end

        // Reset state
        repeat (3) tick();
        chk("reset rd_data d64", if64.rd_data, '0);
        chk("reset rd_data d8", if8.rd_data, '0);
        chk("reset trig_pos d64", EW'(if64.trig_pos), '0);
        reset = 0;
        tick();

        // No match: 10 eligible entries, stage0 = 1..10
        start(5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 10; i++) begin sw[0] = i; tick(); end
        chk("t1 state", EW'(if64.state), EW'(1));
        chk("t1 count", EW'(if64.count), EW'(10));
        chk("t1 d8 count", EW'(if8.count), EW'(8));
        chk("t1 d8 wrapped", EW'(if8.wrapped), EW'(1));
        freeze(); rd_idx = 0; tick();
        chk("t1 rd0 stage0", EW'(if64.rd_data[IW-1:0]), EW'(1));
        chk("t1 rd0 ts", EW'(if64.rd_data[EW-1 -: TSW]), EW'(0));
        rd_idx = 9; tick();
        chk("t1 rd9 stage0", EW'(if64.rd_data[IW-1:0]), EW'(10));
        chk("t1 rd9 ts", EW'(if64.rd_data[EW-1 -: TSW]), EW'(9));
        chk("t1 d8 rd1 stage0", EW'(if8.rd_data[IW-1:0]), EW'(4));

        // Trigger on stage2 at cycle 7, 3 post entries
        start(3, 2, 32'h00A0_0005, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 10; i++) begin
            sw[0] = i; sw[2] = (i == 7) ? 32'h00A0_0005 : 32'h0;
            tick();
            if (i == 7) chk("t2 post after trig", EW'(if64.state), EW'(2));
        end
        chk("t2 state", EW'(if64.state), EW'(3));
        chk("t2 count", EW'(if64.count), EW'(10));
        chk("t2 trig_pos", EW'(if64.trig_pos), EW'(6));
        chk("t2 d8 trig_pos", EW'(if8.trig_pos), EW'(4));
        sw[0] = 11; sw[2] = 0; tick(); tick();
        chk("t2 frozen count", EW'(if64.count), EW'(10));
        rd_idx = 6; tick();
        chk("t2 rd trig word", EW'(if64.rd_data[2*IW +: IW]), EW'(32'h00A0_0005));

        // Wrap: 20 entries, trigger on 21st, 2 post entries
        start(2, 0, 32'h0000_0BAD, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 23; i++) begin sw[0] = (i == 21) ? 32'h0BAD : i; tick(); end
        chk("t3 d8 state", EW'(if8.state), EW'(3));
        chk("t3 d8 wrapped", EW'(if8.wrapped), EW'(1));
        chk("t3 d8 count", EW'(if8.count), EW'(8));
        chk("t3 d8 trig_pos", EW'(if8.trig_pos), EW'(5));
        chk("t3 d64 trig_pos", EW'(if64.trig_pos), EW'(20));
        rd_idx = 0; tick();
        chk("t3 d8 rd0 stage0", EW'(if8.rd_data[IW-1:0]), EW'(16));

        // Stall filtering, match only on a stalled cycle
        tv[0] = '{0, 32'd1, 1};  tv[1] = '{1, 32'd2, 1};      tv[2] = '{0, 32'd3, 2};
        tv[3] = '{0, 32'd4, 3};  tv[4] = '{1, 32'hDEAD, 3};   tv[5] = '{1, 32'd6, 3};
        tv[6] = '{0, 32'd7, 4};  tv[7] = '{1, 32'd8, 4};      tv[8] = '{0, 32'd9, 5};
        tv[9] = '{0, 32'd10, 6};
        rb_w  = '{1, 3, 4, 7, 9, 10};
        rb_ts = '{0, 2, 3, 6, 8, 9};
        start(0, 0, 32'hDEAD, 32'hFFFF_FFFF, 1);
        for (int i = 0; i < 10; i++) begin
            stall = tv[i].st; sw[0] = tv[i].w; tick();
            chk($sformatf("t4 row%0d count", i), EW'(if64.count), EW'(tv[i].ecnt));
            chk($sformatf("t4 row%0d state", i), EW'(if64.state), EW'(1));
        end
        freeze();
        for (int j = 0; j < 6; j++) begin
            rd_idx = j; tick();
            chk($sformatf("t4 rd%0d stage0", j), EW'(if64.rd_data[IW-1:0]), EW'(rb_w[j]));
            chk($sformatf("t4 rd%0d ts", j), EW'(if64.rd_data[EW-1 -: TSW]), EW'(rb_ts[j]));
        end

        // post_count 0: DONE right after the trigger entry
        start(0, 1, 32'h77, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 5; i++) begin
            sw[1] = (i == 5) ? 32'h77 : i; tick();
            if (i == 4) chk("t5 armed", EW'(if64.state), EW'(1));
        end
        chk("t5 state", EW'(if64.state), EW'(3));
        chk("t5 trig_pos", EW'(if64.trig_pos), EW'(4));

        // arm coincident with a match, then reset while in POST
        start(5, 0, 32'h55, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 3; i++) begin sw[0] = i; tick(); end
        arm = 1; sw[0] = 32'h55; tick(); arm = 0;
        chk("t6 arm+match state", EW'(if64.state), EW'(1));
        chk("t6 arm+match count", EW'(if64.count), EW'(0));
        tick();
        chk("t6 post", EW'(if64.state), EW'(2));
        sw[0] = 0; tick();
        reset = 1; tick(); reset = 0;
        chk("t6 reset state", EW'(if64.state), EW'(0));
        chk("t6 reset count", EW'(if64.count), EW'(0));
        chk("t6 reset rd_data", if64.rd_data, '0);
        tick();

        // Randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            start($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 31),
                  ($urandom_range(0, 4) == 0) ? 32'h0 : 32'h1F, $urandom_range(0, 1));
            for (int c = 0; c < 50; c++) begin
                for (int s = 0; s < STAGES; s++) sw[s] = $urandom_range(0, 31);
                stall = ($urandom_range(0, 3) == 0);
                arm = ($urandom_range(0, 59) == 0);
                tick();
            end
            freeze();
            for (int j = 0; j < 8; j++) begin
                rd_idx = $urandom_range(0, 63);
                tick();
                for (int k = 0; k < 2; k++)
                    chk($sformatf("rand d%0d rd%0d", dep(k), rd_idx), dut_rd(k),
                        exp_rd(k, rd_idx % dep(k)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_trace_capture.md
# pipeline_trace_capture

Synthesizable, parametrised capture of per-stage instruction words from the pipelined processor into a circular trace buffer. It arms on command and fires on a masked match at a selected stage. It then records a programmable number of post-trigger cycles and freezes for readout. It optionally filters stall cycles. It sits beside `processor`, fed by the stage pipeline-register outputs and the hazard unit's stall line, and replaces simulation-only `$monitor` tracing for on-FPGA debug.

## Interface
- `STAGES`, 5, number of traced stage instruction words (IF/ID in, IF/ID, ID/EX, EX/MEM, MEM/WB).
- `IW`, 32, instruction word width.
- `DEPTH`, 64, trace entries; power of two, ≥ 4.
- `AW`, log2(DEPTH), entry index width.
- `TSW`, 16, timestamp width.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stage_instr`  in  STAGES*IW  stage s occupies bits [s*IW +: IW].
- `stall`  in  1  pipeline stall asserted this cycle.
- `arm`  in  1  one-cycle pulse: clear buffer, start capture.
- `filter_stalls`  in  1  1 = stall cycles are neither written nor counted.
- `trig_stage`  in  3  stage index compared; values ≥ STAGES never match.
- `trig_value`, `trig_mask`  in  IW  match when (word & mask) == (value & mask).
- `post_count`  in  AW  entries written after the trigger entry; sampled at arm.
- `rd_idx`  in  AW  read index, 0 = oldest valid entry.
- `rd_data`  out  STAGES*IW+1+TSW  {timestamp, stall, stage words}; reset 0.
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3; reset IDLE.
- `count`  out  AW+1  valid entries, saturates at DEPTH; reset 0.
- `trig_pos`  out  AW  index (oldest-relative) of trigger entry, valid in DONE; reset 0.
- `wrapped`  out  1  buffer overwrote at least one entry since arm; reset 0.

## Operation
- A cycle is eligible when `!(filter_stalls && stall)`. Only eligible cycles write, trigger, or decrement.
- IDLE: no writes. `arm` → ARMED. Clear `wr_ptr`, `count`, `wrapped`, and timestamp. Latch `post_count`.
- ARMED: each eligible cycle writes an entry at `wr_ptr` and increments `wr_ptr` mod DEPTH. If the written word matches the trigger, record that entry's physical address. Load `post_rem` = latched `post_count` → POST. If `post_rem` = 0, go straight to DONE.
- POST: each eligible cycle writes and decrements `post_rem`. The write that takes `post_rem` to 0 → DONE.
- DONE: frozen. Only reads and `arm` are accepted.
- `arm` in any state restarts as from IDLE. `arm` has priority over trigger and write in the same cycle; that cycle is not captured.
- Timestamp = cycles since arm, counting all cycles including filtered ones. It wraps at 2^TSW.
- `count` increments per write up to DEPTH. A write at `count` = DEPTH sets `wrapped`.
- Oldest physical address = `wrapped` ? `wr_ptr` : 0. Read physical = (oldest + `rd_idx`) mod DEPTH.
- `rd_idx` ≥ `count` returns all zeros.
- `trig_pos` = (trigger physical − oldest) mod DEPTH, computed on entry to DONE.
- A `post_count` ≥ DEPTH−1 overwrites the trigger entry; `trig_pos` is then meaningless. This is permitted and not flagged.

## Timing
- Entry written at the edge ending the sampled cycle. `count` and `state` update at that same edge.
- Trigger-cycle data is the first entry with state = POST visible next cycle.
- Read latency is 1 cycle: `rd_data` reflects the `rd_idx` from the previous edge. Reads during ARMED/POST are allowed but return live contents.
- Reset mid-capture: next cycle state = IDLE, `count` = 0, `wrapped` = 0, `rd_data` = 0. RAM contents are don't-care.

## Structure
- Package `trace_pkg`: state encoding constants, and an entry-width function STAGES*IW+1+TSW.
- Sub-module `trace_ram`: simple dual-port synchronous RAM, DEPTH × entry width, one write port and a registered read port. Inferred as block RAM.
- The FSM, pointers, match compare, and timestamp live in the top module.

## Test plan
- Arm, no match, 10 eligible cycles with stage0 = 1..10 → state ARMED, `count` = 10, `rd_idx` 0 reads stage0 = 1, `rd_idx` 9 reads stage0 = 10.
- `post_count` = 3, stage2 word 0x00A0_0005 at cycle 7, mask 0xFFFF_FFFF → DONE after entry 10, `count` = 10, `trig_pos` = 6.
- DEPTH = 8, 20 eligible cycles then trigger with `post_count` = 2 → `wrapped` = 1, `count` = 8, `trig_pos` = 5, `rd_idx` 0 holds cycle-16 data.
- `filter_stalls` = 1, `stall` high on 4 of 10 cycles, matching word on a stalled cycle → no trigger, `count` = 6, timestamps of entries skip stalled values.
- `post_count` = 0 → DONE the cycle after the trigger. `trig_pos` = `count` − 1.
- `arm` coincident with a matching word, and reset asserted in POST → first: ARMED, `count` = 0; second: IDLE, `count` = 0, `rd_data` = 0.
